// File: rtl/csa_pkg.sv
// Shared definitions for the multi-channel DVB-CSA key schedule:
// round count, bit permutation table, permutation helper and FSM states.
package csa_pkg;

    localparam int CSA_KS_ROUNDS = 56;

    // p(i) for i = 1..64, stored 0-based: CSA_KS_PERM[i-1] = p(i)
    localparam int CSA_KS_PERM [64] = '{
        18, 36,  9,  7, 42, 49, 29, 21, 28, 54, 62, 50, 19, 33, 59, 64,
        24, 20, 37, 39,  2, 53, 27,  1, 34,  4, 13, 14, 57, 40, 26, 41,
        51, 35, 52, 12, 22, 48, 30, 58, 45, 31,  8, 25, 23, 47, 61, 17,
        60,  5, 56, 43, 11,  6, 10, 44, 32, 63, 46, 15,  3, 38, 16, 55
    };

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_RUN  = 1'b1
    } ks_state_t;

    // Key bit k (1 = MSB) lives at vector bit 64-k; new[p(i)] <- old[i]
    function automatic logic [63:0] csa_ks_permute(input logic [63:0] v);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            r[6'(64 - CSA_KS_PERM[i])] = v[6'(63 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_key_sched_mc_if.sv
// Key-load, request and round-key stream signals of csa_key_sched_mc.
// slave = key schedule side, master = key writer / descrambler side.
interface csa_key_sched_mc_if #(
    parameter int CH_W = 3
) ();
    logic            key_wr;
    logic [CH_W-1:0] key_ch;
    logic            key_par;
    logic [63:0]     key_data;
    logic            req_valid;
    logic            req_ready;
    logic [CH_W-1:0] req_ch;
    logic            req_par;
    logic            rk_valid;
    logic            rk_ready;
    logic [7:0]      rk_data;
    logic [5:0]      rk_idx;
    logic            rk_last;
    logic            err;

    modport slave (
        input  key_wr, key_ch, key_par, key_data,
        input  req_valid, req_ch, req_par,
        output req_ready,
        output rk_valid, rk_data, rk_idx, rk_last, err,
        input  rk_ready
    );

    modport master (
        output key_wr, key_ch, key_par, key_data,
        output req_valid, req_ch, req_par,
        input  req_ready,
        input  rk_valid, rk_data, rk_idx, rk_last, err,
        output rk_ready
    );
endinterface

// File: rtl/csa_key_store.sv
// Control-word bank: one write port, one combinational read port.
// CSA_KS_PARITY_EN gives each channel an even and an odd entry.
module csa_key_store #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic            wr_par,
    input  logic [63:0]     wr_data,
    input  logic [CH_W-1:0] rd_ch,
    input  logic            rd_par,
    output logic [63:0]     rd_data
);
`ifdef CSA_KS_PARITY_EN
    localparam int NPAR = 2;

    function automatic logic sel(input logic [CH_W-1:0] ch, input logic par, input int e);
        return (ch == CH_W'(e / 2)) && (par == 1'(e % 2));
    endfunction
`else
    localparam int NPAR = 1;

    logic par_unused_s;
    assign par_unused_s = wr_par ^ rd_par;

    function automatic logic sel(input logic [CH_W-1:0] ch, input logic par, input int e);
        return (par == par) && (ch == CH_W'(e));
    endfunction
`endif

    localparam int DEPTH = NUM_CH * NPAR;

    logic [63:0] mem_r [DEPTH];

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        // Entry register; writes naming a channel outside the bank match no entry
        always_ff @(posedge clk) begin
            if (!nrst) begin
                mem_r[e] <= 64'd0;
            end else if (wr_en && sel(wr_ch, wr_par, e)) begin
                mem_r[e] <= wr_data;
            end
        end
    end

    // Read mux
    always_comb begin
        rd_data = 64'd0;
        for (int e = 0; e < DEPTH; e++) begin
            rd_data = sel(rd_ch, rd_par, e) ? mem_r[e] : rd_data;
        end
    end

endmodule

// File: rtl/csa_key_sched_mc.sv
// Multi-channel DVB-CSA block-cipher key schedule: expands a stored control
// word into 56 round-key bytes. Optional build macro: CSA_KS_PARITY_EN.
module csa_key_sched_mc
    import csa_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic               clk,
    input logic               nrst,
    csa_key_sched_mc_if.slave bus
);
    localparam logic [5:0] NI_START = 6'(CSA_KS_ROUNDS - 1);

    ks_state_t   state_r;
    ks_state_t   state_nxt_s;
    logic [5:0]  ni_r;
    logic [63:0] wk_r;
    logic        err_r;
    logic [63:0] rd_data_s;
    logic        ch_ok_s;
    logic        start_s;
    logic        beat_s;
    logic [5:0]  shift_s;
    logic [7:0]  byte_s;

    csa_key_store #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_store (
        .clk     (clk),
        .nrst    (nrst),
        .wr_en   (bus.key_wr),
        .wr_ch   (bus.key_ch),
        .wr_par  (bus.key_par),
        .wr_data (bus.key_data),
        .rd_ch   (bus.req_ch),
        .rd_par  (bus.req_par),
        .rd_data (rd_data_s)
    );

    assign ch_ok_s = (32'(bus.req_ch) < NUM_CH);
    assign start_s = (state_r == KS_IDLE) && bus.req_valid && ch_ok_s;
    assign beat_s  = (state_r == KS_RUN) && bus.rk_ready;

    // Byte b = ni[2:0] sits at key bits 8b+1..8b+8, i.e. 56-8b above the LSB
    assign shift_s = 6'd56 - {ni_r[2:0], 3'd0};
    assign byte_s  = 8'(wk_r >> shift_s);

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= KS_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            KS_IDLE: state_nxt_s = start_s ? KS_RUN : KS_IDLE;
            KS_RUN:  state_nxt_s = (beat_s && (ni_r == 6'd0)) ? KS_IDLE : KS_RUN;
            default: state_nxt_s = KS_IDLE;
        endcase
    end

    // Output logic; stream outputs are forced to zero outside RUN
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rk_valid  = 1'b0;
        bus.rk_data   = 8'd0;
        bus.rk_idx    = 6'd0;
        bus.rk_last   = 1'b0;
        bus.err       = err_r;
        case (state_r)
            KS_IDLE: bus.req_ready = 1'b1;
            KS_RUN: begin
                bus.rk_valid = 1'b1;
                bus.rk_data  = byte_s ^ {5'd0, ni_r[5:3]};
                bus.rk_idx   = NI_START - ni_r;
                bus.rk_last  = (ni_r == 6'd0);
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

    // Working register, round counter and error pulse
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wk_r  <= 64'd0;
            ni_r  <= NI_START;
            err_r <= 1'b0;
        end else begin
            err_r <= (state_r == KS_IDLE) && bus.req_valid && !ch_ok_s;
            if (start_s) begin
                wk_r <= rd_data_s;
                ni_r <= NI_START;
            end else if (beat_s && (ni_r != 6'd0)) begin
                ni_r <= ni_r - 6'd1;
                // Last byte of an 8-byte group: move to the next key permutation
                if (ni_r[2:0] == 3'd0) begin
                    wk_r <= csa_ks_permute(wk_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_key_sched_mc.sv
// Self-checking bench for csa_key_sched_mc: a per-cycle comparison against a
// behavioural key-schedule model, plus directed literal checks.
module tb_csa_key_sched_mc;
    localparam int NUM_CH = 6;
    localparam int CH_W   = 3;

    typedef logic [7:0] stream_t [56];

    localparam int P [64] = '{
        18, 36,  9,  7, 42, 49, 29, 21, 28, 54, 62, 50, 19, 33, 59, 64,
        24, 20, 37, 39,  2, 53, 27,  1, 34,  4, 13, 14, 57, 40, 26, 41,
        51, 35, 52, 12, 22, 48, 30, 58, 45, 31,  8, 25, 23, 47, 61, 17,
        60,  5, 56, 43, 11,  6, 10, 44, 32, 63, 46, 15,  3, 38, 16, 55
    };

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    csa_key_sched_mc_if #(.CH_W(CH_W)) bus ();

    csa_key_sched_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        m_busy;
    int          m_pos;
    stream_t     m_stream;
    logic        m_err;
    logic [63:0] m_store [NUM_CH][2];
    logic [7:0]  dut_log [56];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Spec bit numbering 1..64, bit 1 = MSB; new[p(i)] = old[i]
    function automatic logic [63:0] perm(input logic [63:0] v);
        logic        nb [1:64];
        logic [63:0] r;
        for (int k = 1; k <= 64; k++) nb[P[k-1]] = v[64-k];
        for (int k = 1; k <= 64; k++) r[64-k] = nb[k];
        return r;
    endfunction

    // Group g of 8 bytes uses the key permuted g times, bytes 7..0 of it, XOR (6-g)
    function automatic stream_t expand(input logic [63:0] key);
        stream_t     s;
        logic [63:0] w;
        w = key;
        for (int g = 0; g < 7; g++) begin
            for (int j = 0; j < 8; j++) begin
                s[g*8+j] = 8'(w >> (8*j)) ^ 8'(6 - g);
            end
            w = perm(w);
        end
        return s;
    endfunction

    function automatic int slot(input logic p);
`ifdef CSA_KS_PARITY_EN
        return int'(p);
`else
        return (p == p) ? 0 : 0;
`endif
    endfunction

    // Behavioural reference: store, job progress and error pulse
    always @(posedge clk) begin
        if (!nrst) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
            m_err  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_store[c][0] <= 64'd0;
                m_store[c][1] <= 64'd0;
            end
        end else begin
            m_err <= !m_busy && bus.req_valid && (int'(bus.req_ch) >= NUM_CH);
            if (!m_busy) begin
                if (bus.req_valid && int'(bus.req_ch) < NUM_CH) begin
                    m_stream <= expand(m_store[bus.req_ch][slot(bus.req_par)]);
                    m_pos    <= 0;
                    m_busy   <= 1'b1;
                end
            end else if (bus.rk_ready) begin
                if (m_pos == 55) m_busy <= 1'b0;
                else m_pos <= m_pos + 1;
            end
            if (bus.key_wr && int'(bus.key_ch) < NUM_CH)
                m_store[bus.key_ch][slot(bus.key_par)] <= bus.key_data;
        end
    end

    // Per-cycle output comparison, and a log of accepted DUT bytes
    always @(negedge clk) begin
        check("cycle",
              {46'd0, bus.req_ready, bus.rk_valid, bus.rk_data, bus.rk_idx, bus.rk_last, bus.err},
              {46'd0, !m_busy, m_busy, (m_busy ? m_stream[m_pos] : 8'h00),
               (m_busy ? 6'(m_pos) : 6'd0), (m_busy && m_pos == 55), m_err});
        if (bus.rk_valid && bus.rk_ready) dut_log[bus.rk_idx] <= bus.rk_data;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_key(input int ch, input logic par, input logic [63:0] data);
        bus.key_wr   = 1'b1;
        bus.key_ch   = CH_W'(ch);
        bus.key_par  = par;
        bus.key_data = data;
        tick();
        bus.key_wr = 1'b0;
    endtask

    // mode 0: ready held high; 1: random ready; 2: random ready plus key writes
    task automatic run_job(input int ch, input logic par, input int mode, output int lat);
        bus.req_valid = 1'b1;
        bus.req_ch    = CH_W'(ch);
        bus.req_par   = par;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.req_ready && lat < 2000) begin
            bus.rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.key_wr   = (mode == 2) && ($urandom_range(0, 3) == 0);
            bus.key_ch   = CH_W'($urandom_range(0, 7));
            bus.key_par  = 1'($urandom_range(0, 1));
            bus.key_data = {$urandom, $urandom};
            tick();
            lat++;
        end
        bus.rk_ready = 1'b1;
        bus.key_wr   = 1'b0;
        if (lat >= 2000) check("job_timeout", 64'(lat), 64'd0);
    endtask

    task automatic check_stream(input string name, input logic [63:0] key);
        stream_t e;
        e = expand(key);
        for (int i = 0; i < 56; i++) check(name, 64'(dut_log[i]), 64'(e[i]));
    endtask

    initial begin
        int          lat;
        int          cnt;
        stream_t     s;
        logic [7:0]  saved [56];
        logic [63:0] k1, k2;

        nrst          = 1'b0;
        bus.key_wr    = 1'b0;
        bus.key_ch    = '0;
        bus.key_par   = 1'b0;
        bus.key_data  = 64'd0;
        bus.req_valid = 1'b0;
        bus.req_ch    = '0;
        bus.req_par   = 1'b0;
        bus.rk_ready  = 1'b1;
        repeat (3) tick();
        check("reset", {46'd0, bus.req_ready, bus.rk_valid, bus.rk_data, bus.rk_idx, bus.rk_last, bus.err},
              {46'd0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0});

        s = expand(64'd0);
        check("model_zero", {32'd0, s[0], s[8], s[48], s[55]}, {32'd0, 8'h06, 8'h05, 8'h00, 8'h00});
        s = expand(64'd1);
        check("model_one", {24'd0, s[0], s[1], s[7], s[8], s[9]}, {24'd0, 8'h07, 8'h06, 8'h06, 8'h05, 8'h07});

        nrst = 1'b1;
        tick();

        run_job(0, 1'b0, 0, lat);
        check("latency", 64'(lat), 64'd56);
        check("zero_stream", {16'd0, dut_log[0], dut_log[7], dut_log[8], dut_log[15], dut_log[48], dut_log[55]},
              {16'd0, 8'h06, 8'h06, 8'h05, 8'h05, 8'h00, 8'h00});

        write_key(0, 1'b0, 64'h0000_0000_0000_0001);
        run_job(0, 1'b0, 0, lat);
        check("one_stream", {24'd0, dut_log[0], dut_log[1], dut_log[7], dut_log[8], dut_log[9]},
              {24'd0, 8'h07, 8'h06, 8'h06, 8'h05, 8'h07});
        for (int i = 0; i < 56; i++) saved[i] = dut_log[i];
        for (int i = 0; i < 56; i++) dut_log[i] = 8'hxx;
        run_job(0, 1'b0, 1, lat);
        for (int i = 0; i < 56; i++) check("stall_stream", 64'(dut_log[i]), 64'(saved[i]));

        k1 = 64'h0123_4567_89AB_CDEF;
        k2 = 64'hF0E1_D2C3_B4A5_9687;
        write_key(3, 1'b0, k1);
        write_key(3, 1'b1, k2);
        run_job(3, 1'b0, 0, lat);
`ifdef CSA_KS_PARITY_EN
        check_stream("ch3_even", k1);
`else
        check_stream("ch3_even", k2);
`endif
        run_job(3, 1'b1, 1, lat);
        check_stream("ch3_odd", k2);

        bus.req_valid = 1'b1;
        bus.req_ch    = CH_W'(NUM_CH);
        tick();
        bus.req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(bus.err);
            check("err_idle", {62'd0, bus.rk_valid, bus.req_ready}, {62'd0, 1'b0, 1'b1});
            tick();
        end
        check("err_pulses", 64'(cnt), 64'd1);

        write_key(2, 1'b0, k1);
        bus.key_wr    = 1'b1;
        bus.key_ch    = CH_W'(2);
        bus.key_par   = 1'b0;
        bus.key_data  = k2;
        run_job(2, 1'b0, 0, lat);
        check_stream("same_edge_old", k1);
        run_job(2, 1'b0, 0, lat);
        check_stream("same_edge_new", k2);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 2))
                write_key($urandom_range(0, 7), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            run_job($urandom_range(0, NUM_CH - 1), 1'($urandom_range(0, 1)), 2, lat);
            repeat ($urandom_range(0, 2)) tick();
        end

        write_key(1, 1'b0, k1);
        bus.req_valid = 1'b1;
        bus.req_ch    = CH_W'(1);
        bus.req_par   = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        cnt = 0;
        while (!(bus.rk_valid && bus.rk_idx == 6'd20) && cnt < 100) begin
            tick();
            cnt++;
        end
        check("reach_idx20", 64'(bus.rk_idx), 64'd20);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("abort", {62'd0, bus.rk_valid, bus.req_ready}, {62'd0, 1'b0, 1'b1});
        tick();
        run_job(1, 1'b0, 0, lat);
        check("restart_first", 64'(dut_log[0]), 64'h06);
        check_stream("restart", 64'd0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_key_sched_mc.md
# csa_key_sched_mc

Multi-channel DVB-CSA block-cipher key schedule. Holds a bank of 64-bit control words, one or two per channel. On request it expands the selected word into the 56-byte block-cipher round-key stream, one byte per accepted beat. It sits between the key-load path (CPU/ECM writer) and the multi-channel descrambler datapath, which pulls round keys with valid/ready.

## Interface
- NUM_CH, default 8: number of channels, minimum 1.
- CH_W, default $clog2(NUM_CH) (1 when NUM_CH = 1): channel index width.
- clk  in  1  clock
- nrst  in  1  reset; synchronous, active-low
- key_wr  in  1  key store write strobe
- key_ch  in  CH_W  write channel
- key_par  in  1  write parity, 0 = even, 1 = odd
- key_data  in  64  key; bit 63 = MSB of first byte (key bit 1)
- req_valid  in  1  expansion request
- req_ready  out  1  high in IDLE
- req_ch  in  CH_W  requested channel
- req_par  in  1  requested parity
- rk_valid  out  1  round-key byte valid
- rk_ready  in  1  consumer accepts byte
- rk_data  out  8  round-key byte
- rk_idx  out  6  round index, 0..55 in emission order
- rk_last  out  1  high with rk_idx = 55
- err  out  1  one-cycle pulse when a request names channel ≥ NUM_CH

## Operation
- Key store: NUM_CH×2 entries of 64 bits, all zero after reset.
  - key_wr with key_ch < NUM_CH writes the entry selected by key_ch and key_par.
  - key_wr with key_ch ≥ NUM_CH is ignored.
- States: IDLE and RUN. Working register wk[1:64]; down-counter ni[5:0].
- IDLE:
  - req_ready = 1.
  - On req_valid with req_ch < NUM_CH: wk ← store entry, ni ← 55, go to RUN.
  - On req_valid with req_ch ≥ NUM_CH: request is consumed, err pulses, state stays IDLE.
- RUN:
  - rk_valid = 1.
  - Byte select: wk byte b = ni[2:0], where byte 0 = wk[1:8] and byte 7 = wk[57:64].
  - rk_data = byte b with its low 3 bits XOR ni[5:3].
  - rk_idx = 55 − ni.
  - rk_data, rk_idx and rk_last are combinational from wk and ni, and stable while rk_valid && !rk_ready.
- Beat: a beat is rk_valid && rk_ready.
  - On a beat with ni ≠ 0: ni decrements by 1.
  - If, in addition, ni[2:0] = 0, wk is permuted on the same edge.
  - On a beat with ni = 0: go to IDLE. No permutation.
- Permutation: new[p(i)] ← old[i] for i = 1..64. p(1..64) = 18,36,9,7,42,49,29,21,28,54,62,50,19,33,59,64,24,20,37,39,2,53,27,1,34,4,13,14,57,40,26,41,51,35,52,12,22,48,30,58,45,31,8,25,23,47,61,17,60,5,56,43,11,6,10,44,32,63,46,15,3,38,16,55.
- The permutation is applied exactly 6 times per job. wk never changes in IDLE.
- Store write and request accept on the same edge, same entry: the job captures the old value; the store holds the new value.
- key_wr during RUN updates the store only; the working copy is unaffected.

## Timing
- Reset values:
  - State IDLE; req_ready = 1.
  - rk_valid = 0, rk_last = 0, err = 0.
  - rk_data = 0, rk_idx = 0.
  - ni = 55, wk = 0.
  - Store all zero.
- Request accepted at edge T: first byte is valid from T+1.
- With rk_ready held high, bytes occupy cycles T+1..T+56. req_ready rises at T+57.
- Peak throughput: 56 bytes per 57 cycles per job.
- Stalls: rk_ready low for any number of cycles holds every output unchanged.
- err is asserted the cycle after the bad request.
- nrst low mid-job aborts it. The next cycle matches the reset values.

## Configuration
- CSA_KS_PARITY_EN defined: two entries per channel; key_par and req_par select the entry.
- CSA_KS_PARITY_EN undefined:
  - One entry per channel; store depth is NUM_CH.
  - key_par and req_par are ignored.
  - All other behaviour is identical.

## Structure
- Shared package csa_pkg holds:
  - CSA_KS_ROUNDS = 56 and CSA_KS_PERM (64-entry table p).
  - A function applying the permutation to a 64-bit vector.
  - State enum ks_state_t {KS_IDLE, KS_RUN}.
- One sub-module, csa_key_store: the register bank with write port and one combinational read port. The FSM, counter and permutation live in the top level.

## Test plan
- Reset then all-zero key, ch 0, rk_ready = 1:
  - rk_data = 0x06 for idx 0–7, 0x05 for idx 8–15, … 0x00 for idx 48–55.
  - rk_last only at idx 55; req_ready returns 57 cycles after accept.
- Key 0x0000000000000001, idx 0–9:
  - idx 0 = 0x07; idx 1–7 = 0x06.
  - idx 8 = 0x05; idx 9 = 0x07 (bit moved to position 55).
- Same key with rk_ready toggled randomly: byte sequence identical to the previous case; outputs constant while stalled.
- Distinct keys written to ch 3 even and odd, then requests for each: each stream matches the software model for its own key. With the macro off, both streams equal the last-written key.
- Request ch = NUM_CH: err pulses once, rk_valid stays 0, req_ready stays 1.
- nrst low at idx 20: rk_valid = 0 next cycle. A new job restarts at idx 0 with correct bytes.
